// File: rtl/gradient_window_sequencer_if.sv
// Pixel-in / window-out handshake bundle between the pixel source and the window sequencer.
interface gradient_window_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 12
);
  logic                     i_pixel_valid;
  logic                     i_start_of_frame;
  logic                     o_pixel_accept;
  logic                     o_window_valid;
  logic                     o_window_sof;
  logic                     o_frame_done;
  logic                     o_sof_error;
  logic                     o_busy;
  logic [2*CNT_WIDTH-1:0]   o_window_count;

  modport master (
    output i_pixel_valid, i_start_of_frame,
    input  o_pixel_accept, o_window_valid, o_window_sof, o_frame_done,
    input  o_sof_error, o_busy, o_window_count
  );

  modport slave (
    input  i_pixel_valid, i_start_of_frame,
    output o_pixel_accept, o_window_valid, o_window_sof, o_frame_done,
    output o_sof_error, o_busy, o_window_count
  );
endinterface

// File: rtl/gradient_window_sequencer.sv
// Raster tracker and window-valid sequencer for the 5x5 gradient kernel.
// Optional per-frame window counter enabled by GRADIENT_SEQ_WINDOW_COUNT_EN.
module gradient_window_sequencer #(
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned CNT_WIDTH   = 12
) (
  input  logic                        i_clk,
  input  logic                        i_areset,
  gradient_window_sequencer_if.slave  bus
);

  localparam int unsigned WIN_W = 2 * CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LP_K_LAST = CNT_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] LP_W_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] LP_H_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_col;
  logic [CNT_WIDTH-1:0] r_row;
  logic [CNT_WIDTH-1:0] w_col_next;
  logic [CNT_WIDTH-1:0] w_row_next;
  logic [CNT_WIDTH-1:0] w_pos_col;
  logic [CNT_WIDTH-1:0] w_pos_row;

  logic w_accept;
  logic w_sof_acc;
  logic w_at_first;
  logic w_at_last;
  logic w_win;
  logic w_win_sof;
  logic w_done;
  logic w_sof_err;

  logic r_window_valid;
  logic r_window_sof;
  logic r_frame_done;
  logic r_sof_error;
  logic r_busy;

  // State register
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state, next raster position and per-pixel events.
  // An accepted SOF pixel is always (0,0), whatever the counters hold.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;

    w_accept   = bus.i_pixel_valid & ((r_state != ST_IDLE) | bus.i_start_of_frame);
    w_sof_acc  = w_accept & bus.i_start_of_frame;
    w_pos_col  = w_sof_acc ? '0 : r_col;
    w_pos_row  = w_sof_acc ? '0 : r_row;
    w_at_first = (w_pos_col == LP_K_LAST) && (w_pos_row == LP_K_LAST);
    w_at_last  = (w_pos_col == LP_W_LAST) && (w_pos_row == LP_H_LAST);
    w_win      = w_accept && (w_pos_row >= LP_K_LAST) && (w_pos_col >= LP_K_LAST);
    w_win_sof  = w_win & w_at_first;
    w_sof_err  = w_sof_acc & (r_state != ST_IDLE);
    w_done     = w_accept & ~w_sof_acc & (r_state == ST_ACTIVE) & w_at_last;

    if (w_accept) begin
      if (w_done) begin
        w_col_next = '0;
        w_row_next = '0;
      end else if (w_pos_col == LP_W_LAST) begin
        w_col_next = '0;
        w_row_next = w_pos_row + CNT_WIDTH'(1);
      end else begin
        w_col_next = w_pos_col + CNT_WIDTH'(1);
        w_row_next = w_pos_row;
      end
    end

    if (w_sof_acc) begin
      w_state_next = ST_FILL;
    end else if (w_accept) begin
      case (r_state)
        ST_FILL:   if (w_at_first) w_state_next = ST_ACTIVE;
        ST_ACTIVE: if (w_at_last)  w_state_next = ST_IDLE;
        default:   w_state_next = r_state;
      endcase
    end
  end

  // Raster counters and registered event pulses
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_col          <= '0;
      r_row          <= '0;
      r_window_valid <= 1'b0;
      r_window_sof   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sof_error    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_col          <= w_col_next;
      r_row          <= w_row_next;
      r_window_valid <= w_win;
      r_window_sof   <= w_win_sof;
      r_frame_done   <= w_done;
      r_sof_error    <= w_sof_err;
      r_busy         <= (w_state_next != ST_IDLE);
    end
  end

`ifdef GRADIENT_SEQ_WINDOW_COUNT_EN
  logic [WIN_W-1:0] r_win_cnt;
  logic [WIN_W-1:0] r_win_count_out;
  logic [WIN_W-1:0] w_win_cnt_inc;

  assign w_win_cnt_inc = r_win_cnt + WIN_W'(w_win);

  // Running count restarts on every accepted SOF; only completed frames publish it
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_win_cnt       <= '0;
      r_win_count_out <= '0;
    end else begin
      if (w_sof_acc) r_win_cnt <= '0;
      else if (w_win) r_win_cnt <= w_win_cnt_inc;
      if (w_done) r_win_count_out <= w_win_cnt_inc;
    end
  end

  assign bus.o_window_count = r_win_count_out;
`else
  assign bus.o_window_count = WIN_W'(0);
`endif

  assign bus.o_pixel_accept = w_accept;
  assign bus.o_window_valid = r_window_valid;
  assign bus.o_window_sof   = r_window_sof;
  assign bus.o_frame_done   = r_frame_done;
  assign bus.o_sof_error    = r_sof_error;
  assign bus.o_busy         = r_busy;

endmodule

// File: doc/gradient_window_sequencer.md
# gradient_window_sequencer

Frame/window sequencer for the 5x5 gradient datapath. It tracks the raster position of an incoming pixel stream and gates which pixels may shift into the kernel line buffers. It also decides which shifted windows are fully populated, and drives the valid and start-of-frame inputs of the Gx/Gy stage with one pulse per complete window. Border windows that would contain stale or previous-frame data are suppressed, and end-of-frame and framing errors are reported.

## Interface
Parameters:
- KERNEL_SIZE, 5, window edge length; the first valid window ends at row/col KERNEL_SIZE-1
- IMG_WIDTH, 640, pixels per line (must be > KERNEL_SIZE)
- IMG_HEIGHT, 480, lines per frame (must be > KERNEL_SIZE)
- CNT_WIDTH, 12, width of column/row counters

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_areset  in  1  asynchronous, active-high reset
- i_pixel_valid  in  1  upstream pixel present this cycle
- i_start_of_frame  in  1  qualifies the pixel at (0,0); meaningful only with i_pixel_valid
- o_pixel_accept  out  1  combinational; kernel buffer shifts this cycle
- o_window_valid  out  1  registered; complete window present in kernel buffer
- o_window_sof  out  1  registered; first complete window of frame
- o_frame_done  out  1  registered one-cycle pulse after last pixel of frame
- o_sof_error  out  1  registered one-cycle pulse on SOF before frame end
- o_busy  out  1  registered; high while state != IDLE
- o_window_count  out  2*CNT_WIDTH  windows emitted in the last completed frame (see Configuration)

## Operation
- States: IDLE, FILL, ACTIVE.
- An accepted pixel is i_pixel_valid & (state != IDLE | i_start_of_frame).
- o_pixel_accept equals the accepted-pixel term. In IDLE, a pixel without SOF is dropped: no accept and no counter change.
- Counters col/row advance on each accepted pixel. col wraps IMG_WIDTH-1 -> 0 with row+1. No advance when i_pixel_valid=0; gaps are allowed.
- An accepted pixel with SOF is always position (0,0) and counters restart.
- Transitions:
  - IDLE -> FILL on accepted SOF pixel.
  - FILL -> ACTIVE on the accepted pixel at (KERNEL_SIZE-1, KERNEL_SIZE-1).
  - ACTIVE -> IDLE on the accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1).
- A window is valid for an accepted pixel with row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1.
- Windows per frame = (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1).
- o_window_sof is asserted together with o_window_valid for the window at (KERNEL_SIZE-1, KERNEL_SIZE-1) only.
- SOF in FILL/ACTIVE:
  - pulse o_sof_error;
  - abandon the current frame with no o_frame_done;
  - restart at (0,0) in FILL.
- SOF on the last pixel position is treated as a mid-frame SOF: error, restart.
- Reset mid-frame: all counters, state and outputs clear immediately. The next frame requires a fresh SOF.

## Timing
- Reset values:
  - o_window_valid, o_window_sof, o_frame_done, o_sof_error, o_busy = 0;
  - o_window_count = 0;
  - state IDLE;
  - col = row = 0.
- o_pixel_accept has 0-cycle latency (combinational from i_pixel_valid, i_start_of_frame, state).
- o_window_valid/o_window_sof/o_sof_error/o_frame_done: 1-cycle latency from the accepted pixel edge, single-cycle pulses.
- o_frame_done is asserted in the same cycle as the final o_window_valid.
- o_busy rises the cycle after the SOF accept and falls the cycle after the last pixel.
- Back-to-back frames: an SOF pixel in the cycle right after the last pixel is accepted normally, with no error.

## Configuration
- Macro GRADIENT_SEQ_WINDOW_COUNT_EN.
- Defined:
  - a 2*CNT_WIDTH counter increments on each emitted window and clears on accepted SOF;
  - o_window_count loads the final count in the cycle o_frame_done asserts and holds until the next frame_done or reset;
  - it is not updated on aborted frames.
- Undefined: counter logic is absent and o_window_count is tied to 0. The port still exists.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL_SIZE=5, continuous valid, SOF on first pixel:
  - 48 accepts, 8 window_valid pulses;
  - first pulse after accepted pixel #36 (0-based) with window_sof=1;
  - frame_done with the pulse after pixel #47;
  - o_window_count=8 (macro on) or 0 (macro off).
- Same frame with i_pixel_valid toggling 1/0: identical window/accept sequence, stretched in time; no extra pulses during gaps.
- Pixels with valid=1 but no SOF while IDLE (10 cycles): o_pixel_accept=0, no outputs. Then an SOF frame behaves as in the first scenario.
- SOF asserted at pixel #20 of a frame:
  - o_sof_error pulses once and no frame_done for the aborted frame;
  - the new frame yields 8 windows, and o_window_count is 8, not 8+partial.
- Two frames back-to-back with SOF immediately after the last pixel: 16 windows, 2 window_sof, 2 frame_done, no sof_error.
- i_areset asserted at pixel #40 for 1 cycle: all outputs 0 asynchronously, state IDLE. The following non-SOF pixels are dropped until the next SOF.
